// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 size/sign encodings
//   - lsu_state_e: IDLE -> WAIT -> DONE access sequencing
//   - helpers: access size, alignment check, store byte enables and lane replication
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } lsu_size_e;

    // Undefined encodings (011, 11x) fall through to a word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SzByte;
            F3_H, F3_HU: return SzHalf;
            F3_W:        return SzWord;
            default:     return SzWord;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SzByte:  return 1'b1;
            SzHalf:  return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SzByte:  return 4'b0001 << a;
            SzHalf:  return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand into every lane so byte enables alone pick the target.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3_size(f3))
            SzByte:  return {4{d[7:0]}};
            SzHalf:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extract/extend.
//   word_i     : raw 32-bit word from memory
//   addr_lo_i  : byte offset within the word
//   funct3_i   : size/sign (B/H sign-extend, BU/HU zero-extend, W and undefined pass through)
//   data_o     : extended load result
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    assign sext = ~funct3_i[2];

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        case (f3_size(funct3_i))
            SzByte:  data_o = {{24{sext & byte_sel[7]}}, byte_sel};
            SzHalf:  data_o = {{16{sext & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues one request per live memory instruction to a
// variable-latency req/ack data port, stalls the pipeline while it is outstanding,
// aligns store data / byte enables and extends load data.
//   clk_i, rst_i (async, active-high)
//   valid_i, is_load_i, is_store_i, funct3_i, addr_i, st_data_i : EX/MEM slot
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o       : request (one-cycle strobe)
//   mem_ack_i, mem_rdata_i                                       : response
//   ld_data_o, done_o, stall_o, misalign_o, err_o                : to mem_wb / hazard logic
module lsu_mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       ld_data_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    lsu_state_e    state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]   ld_q;

    logic        access;
    logic        aligned;
    logic        issue;
    logic        timeout;
    logic [31:0] ld_aligned;

    assign access  = valid_i & (is_load_i | is_store_i);
    assign aligned = f3_aligned(funct3_i, addr_i[1:0]);
    assign issue   = (state_q == IDLE) & access & aligned;
    // Ack on the final WAIT cycle wins over the timeout.
    assign timeout = (state_q == WAIT) & ~mem_ack_i & (cnt_q == CntW'(TIMEOUT - 1));

    // addr_i and funct3_i are held by the stall, so extraction can happen at ack time.
    lsu_load_align u_load_align (
        .word_i    (mem_rdata_i),
        .addr_lo_i (addr_i[1:0]),
        .funct3_i  (funct3_i),
        .data_o    (ld_aligned)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ld_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ack_i) begin
                        // Stores capture 0 so ld_data_o stays quiet on their DONE cycle.
                        ld_q    <= (is_load_i & ~is_store_i) ? ld_aligned : 32'h0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        ld_q    <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        ld_data_o   = '0;
        done_o      = 1'b0;
        stall_o     = 1'b0;
        misalign_o  = 1'b0;
        err_o       = 1'b0;
        // Outputs are combinational on the slot inputs; force them quiet during reset.
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (access && aligned) begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = is_store_i;
                        mem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
                        mem_wdata_o = is_store_i ? store_wdata(funct3_i, st_data_i) : 32'h0;
                        mem_be_o    = is_store_i ? store_be(funct3_i, addr_i[1:0]) : 4'b1111;
                        stall_o     = 1'b1;
                    end else if (access) begin
                        misalign_o = 1'b1;
                        done_o     = 1'b1;
                    end
                end
                WAIT: begin
                    stall_o = 1'b1;
                    err_o   = timeout;
                end
                DONE: begin
                    done_o    = 1'b1;
                    ld_data_o = ld_q;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned ADDR_W  = 32;

    logic              clk_i;
    logic              rst_i;
    logic              valid_i;
    logic              is_load_i;
    logic              is_store_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       st_data_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;
    logic [31:0]       ld_data_o;
    logic              done_o;
    logic              stall_o;
    logic              misalign_o;
    logic              err_o;

    lsu_mem_stage #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .is_load_i   (is_load_i),
        .is_store_i  (is_store_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .st_data_i   (st_data_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .ld_data_o   (ld_data_o),
        .done_o      (done_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle, set by the stimulus from the model.
    logic        e_req, e_we, e_done, e_stall, e_mis, e_err;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_be;
    bit          cmp_en = 1'b0;

    int          stall_cnt, req_cnt, mis_cnt, err_cnt;
    logic [31:0] last_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        e_req = 0; e_we = 0; e_done = 0; e_stall = 0; e_mis = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_ld = 0; e_be = 0;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f3);
        int          sz = m_size(f3);
        int          sh = int'(addr[1:0]) * 8;
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v = (word >> sh) & mask;
        if (f3[2] == 1'b0 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr,
                                        input bit st);
        int sz = m_size(f3);
        if (!st || sz == 4) return 4'hF;
        if (sz == 1) return 4'(1 << addr[1:0]);
        return 4'(3 << addr[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = m_size(f3);
        if (sz == 1) return {24'h0, d[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("mem_req",   32'(mem_req_o),   32'(e_req));
            check("mem_we",    32'(mem_we_o),    32'(e_we));
            check("mem_addr",  mem_addr_o,       e_addr);
            check("mem_wdata", mem_wdata_o,      e_wdata);
            check("mem_be",    32'(mem_be_o),    32'(e_be));
            check("ld_data",   ld_data_o,        e_ld);
            check("done",      32'(done_o),      32'(e_done));
            check("stall",     32'(stall_o),     32'(e_stall));
            check("misalign",  32'(misalign_o),  32'(e_mis));
            check("err",       32'(err_o),       32'(e_err));
            if (stall_o)    stall_cnt++;
            if (mem_req_o)  req_cnt++;
            if (misalign_o) mis_cnt++;
            if (err_o)      err_cnt++;
            if (done_o)     last_ld = ld_data_o;
        end
    end

    task automatic clr_counts();
        stall_cnt = 0; req_cnt = 0; mis_cnt = 0; err_cnt = 0; last_ld = 32'hxxxxxxxx;
    endtask

    // wait_n: WAIT cycle (1-based) on which ack arrives; 0 means never.
    task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int wait_n, input logic [31:0] rdata);
        bit aligned;
        bit acked;
        aligned = (int'(addr[1:0]) % m_size(f3)) == 0;
        acked = 1'b0;
        valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        addr_i = addr; st_data_i = sdata;
        set_idle();
        if (!aligned) begin
            e_done = 1; e_mis = 1;
            @(posedge clk_i); #1;
        end else begin
            e_req = 1; e_we = st; e_addr = {addr[31:2], 2'b00};
            e_wdata = st ? m_wdata(f3, sdata) : 32'h0;
            e_be = m_be(f3, addr, st); e_stall = 1;
            @(posedge clk_i); #1;
            set_idle(); e_stall = 1;
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                acked = (k == wait_n - 1);
                mem_ack_i = acked;
                mem_rdata_i = acked ? rdata : $urandom();
                e_err = !acked && (k == int'(TIMEOUT) - 1);
                @(posedge clk_i); #1;
                if (acked || k == int'(TIMEOUT) - 1) break;
            end
            mem_ack_i = 0; mem_rdata_i = $urandom();
            set_idle(); e_done = 1;
            e_ld = (acked && ld && !st) ? m_load(rdata, addr, f3) : 32'h0;
            @(posedge clk_i); #1;
        end
        valid_i = 0; is_load_i = 0; is_store_i = 0;
        set_idle();
    endtask

    initial begin
        rst_i = 1; valid_i = 1; is_load_i = 1; is_store_i = 0; funct3_i = 3'b010;
        addr_i = 32'h100; st_data_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        set_idle(); clr_counts();
        cmp_en = 1;
        // Live load held during reset must not leak onto the outputs.
        repeat (2) @(posedge clk_i);
        #1; rst_i = 0; valid_i = 0; is_load_i = 0;
        @(posedge clk_i); #1;

        // Spurious ack in IDLE.
        mem_ack_i = 1; mem_rdata_i = 32'h12345678;
        @(posedge clk_i); #1; mem_ack_i = 0;

        // Model pins.
        check("model_lb",  m_load(32'h80FF1234, 32'h103, 3'b000), 32'hFFFFFF80);
        check("model_lbu", m_load(32'h80FF1234, 32'h103, 3'b100), 32'h00000080);
        check("model_lhu", m_load(32'h80FF1234, 32'h102, 3'b101), 32'h000080FF);
        check("model_sh_be", 32'(m_be(3'b001, 32'h202, 1'b1)), 32'hC);
        check("model_sb_wd", m_wdata(3'b000, 32'hAB), 32'hABABABAB);

        // LW, ack on second WAIT cycle.
        clr_counts();
        access(1, 0, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF);
        check("lw_ld_lit", last_ld, 32'hDEADBEEF);
        check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        check("lw_req_cycles", 32'(req_cnt), 32'd1);

        clr_counts();
        access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF1234);
        check("lb_ld_lit", last_ld, 32'hFFFFFF80);
        check("lb_stall_cycles", 32'(stall_cnt), 32'd2);
        access(1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF1234);
        check("lbu_ld_lit", last_ld, 32'h00000080);
        access(1, 0, 3'b101, 32'h102, 0, 3, 32'h80FF1234);
        check("lhu_ld_lit", last_ld, 32'h000080FF);
        access(1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF1234);
        access(1, 0, 3'b001, 32'h100, 0, 2, 32'h80FF9234);
        access(1, 0, 3'b000, 32'h101, 0, 1, 32'h80FF1234);

        // Stores.
        access(0, 1, 3'b000, 32'h201, 32'h000000AB, 1, 32'h55555555);
        access(0, 1, 3'b001, 32'h202, 32'h1234CDEF, 2, 32'h55555555);
        access(0, 1, 3'b010, 32'h204, 32'hA5A5_0F0F, 1, 32'h55555555);
        access(0, 1, 3'b000, 32'h203, 32'h00000077, 1, 32'h0);

        // Misaligned.
        clr_counts();
        access(1, 0, 3'b010, 32'h102, 0, 1, 32'h0);
        check("mis_pulses", 32'(mis_cnt), 32'd1);
        check("mis_no_req", 32'(req_cnt), 32'd0);
        check("mis_no_stall", 32'(stall_cnt), 32'd0);
        access(0, 1, 3'b001, 32'h201, 32'h1234, 1, 32'h0);
        access(1, 0, 3'b101, 32'h103, 0, 1, 32'h0);

        // Undefined funct3 behaves as W.
        access(1, 0, 3'b011, 32'h108, 0, 1, 32'h89ABCDEF);
        access(1, 0, 3'b111, 32'h10C, 0, 2, 32'h01234567);
        access(1, 0, 3'b110, 32'h10A, 0, 1, 32'h0);

        // Timeout with no ack.
        clr_counts();
        access(1, 0, 3'b010, 32'h300, 0, 0, 32'h0);
        check("to_err_pulses", 32'(err_cnt), 32'd1);
        check("to_stall_cycles", 32'(stall_cnt), 32'd17);
        check("to_ld_zero", last_ld, 32'h0);

        // Ack on the exact timeout cycle wins.
        clr_counts();
        access(1, 0, 3'b010, 32'h304, 0, int'(TIMEOUT), 32'h0BADF00D);
        check("tack_no_err", 32'(err_cnt), 32'd0);
        check("tack_ld_lit", last_ld, 32'h0BADF00D);

        // Reset in the middle of WAIT.
        valid_i = 1; is_load_i = 1; is_store_i = 0; funct3_i = 3'b010; addr_i = 32'h400;
        set_idle();
        e_req = 1; e_addr = 32'h400; e_be = 4'hF; e_stall = 1;
        @(posedge clk_i); #1;
        set_idle(); e_stall = 1;
        repeat (2) @(posedge clk_i);
        #2; rst_i = 1;
        #1;
        check("rst_async_stall", 32'(stall_o), 32'd0);
        check("rst_async_req", 32'(mem_req_o), 32'd0);
        set_idle();
        @(posedge clk_i); #1; valid_i = 0; is_load_i = 0;
        @(posedge clk_i); #1; rst_i = 0;
        clr_counts();
        @(posedge clk_i); #1; mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1; mem_ack_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check("late_ack_no_done", last_ld, 32'hxxxxxxxx);

        // Normal access after reset recovery.
        access(1, 0, 3'b000, 32'h500, 0, 1, 32'h0000007F);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
